// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter
// -----------------
// Parametrised multi-digit cascaded modulo counter. Every digit counts modulo
// BASE. Digit 0 is the least significant digit. A digit steps only when all
// digits below it sit at their terminal value for the current direction, so
// the chain behaves like a single base-BASE up/down counter.
//
// Optional feature (macro BCD_CHAIN_SAT_EN):
//   When defined, the 1-bit input 'sat' is added. When sat=1 and the chain is
//   at its terminal value, an enabled count holds instead of wrapping.
//   When the macro is undefined, the counter always wraps.
//
// Parameters:
//   DIGITS : number of cascaded digits (1..8)
//   BASE   : modulus of every digit (2..16)
//   DW     : bits per digit, must satisfy 2**DW >= BASE
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   r      : asynchronous active-high reset, clears all digits
//   clr    : synchronous clear (highest synchronous priority)
//   ld     : synchronous parallel load of din (digits >= BASE load BASE-1)
//   ce     : count enable
//   up     : direction, 1 = up, 0 = down (takes effect combinationally)
//   din    : load value, digit i at [i*DW +: DW]
//   sat    : saturate at the terminal value (only with BCD_CHAIN_SAT_EN)
//   Q      : registered count, same packing as din
//   dig_tc : per-digit terminal flags for the current direction
//   TC     : chain terminal, AND of all dig_tc bits
//   CEO    : cascade enable out, ce & TC & ~ld & ~clr
module bcd_chain_counter #(
  parameter int DIGITS = 4,
  parameter int BASE   = 10,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 clr,
  input  logic                 ce,
  input  logic                 up,
  input  logic                 ld,
  input  logic [DIGITS*DW-1:0] din,
`ifdef BCD_CHAIN_SAT_EN
  input  logic                 sat,
`endif
  output logic [DIGITS*DW-1:0] Q,
  output logic [DIGITS-1:0]    dig_tc,
  output logic                 TC,
  output logic                 CEO
);

  localparam logic [DW-1:0] MAXD = DW'(BASE - 1);

  logic [DIGITS*DW-1:0] qNext;
  logic [DIGITS-1:0]    carry;
  logic                 satHold;

  genvar gi;

  // Terminal flag of each digit follows 'up' directly, so a direction change
  // re-interprets the flags in the same cycle.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_tc
      assign dig_tc[gi] = up ? (Q[gi*DW +: DW] == MAXD) : (Q[gi*DW +: DW] == '0);
    end
  endgenerate

  // carry[i] is set when every lower digit is terminal; built from dig_tc
  // slices rather than a ripple on itself to keep the logic loop-free.
  assign carry[0] = 1'b1;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_carry
      assign carry[gi] = &dig_tc[gi-1:0];
    end
  endgenerate

  assign TC  = &dig_tc;
  assign CEO = ce & TC & ~ld & ~clr;

`ifdef BCD_CHAIN_SAT_EN
  assign satHold = sat & TC;
`else
  assign satHold = 1'b0;
`endif

  // Next-state selection: clr > ld > ce > hold.
  always_comb begin
    qNext = Q;
    if (clr) begin
      qNext = '0;
    end else if (ld) begin
      for (int i = 0; i < DIGITS; i++) begin
        qNext[i*DW +: DW] = (din[i*DW +: DW] > MAXD) ? MAXD : din[i*DW +: DW];
      end
    end else if (ce && !satHold) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry[i]) begin
          if (up) begin
            qNext[i*DW +: DW] = (Q[i*DW +: DW] == MAXD) ? '0 : Q[i*DW +: DW] + 1'b1;
          end else begin
            qNext[i*DW +: DW] = (Q[i*DW +: DW] == '0) ? MAXD : Q[i*DW +: DW] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      Q <= '0;
    end else begin
      Q <= qNext;
    end
  end

endmodule

// File: tb/tb_bcd_chain_counter.sv
// tb_bcd_chain_counter
// --------------------
// Self-checking bench for bcd_chain_counter (DIGITS=4, BASE=10). The reference
// model keeps the count as a single integer in [0, BASE**DIGITS) and applies
// the chain rules arithmetically; digit packing and terminal flags are derived
// from that integer.
module tb_bcd_chain_counter;

  localparam int DIGITS = 4;
  localparam int BASE   = 10;
  localparam int DW     = 4;
  localparam int W      = DIGITS * DW;
  localparam int MODN   = BASE ** DIGITS;
`ifdef BCD_CHAIN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              r;
  logic              clr;
  logic              ce;
  logic              up;
  logic              ld;
  logic [W-1:0]      din;
  logic              satIn;
  logic [W-1:0]      q;
  logic [DIGITS-1:0] digTc;
  logic              tc;
  logic              ceo;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned model      = 0;

  bcd_chain_counter #(.DIGITS(DIGITS), .BASE(BASE), .DW(DW)) dut (
    .clk    (clk),
    .r      (r),
    .clr    (clr),
    .ce     (ce),
    .up     (up),
    .ld     (ld),
    .din    (din),
`ifdef BCD_CHAIN_SAT_EN
    .sat    (satIn),
`endif
    .Q      (q),
    .dig_tc (digTc),
    .TC     (tc),
    .CEO    (ceo)
  );

  always #5 clk = ~clk;

  // Integer count -> packed digits, least significant digit first.
  function automatic logic [W-1:0] toPacked(input int unsigned n);
    logic [W-1:0] p;
    int unsigned  v;
    p = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      p[i*DW +: DW] = DW'(v % BASE);
      v = v / BASE;
    end
    return p;
  endfunction

  // Load value -> integer count, with out-of-range digits clamped to BASE-1.
  function automatic int unsigned fromLoad(input logic [W-1:0] v);
    int unsigned n;
    int unsigned w;
    int unsigned d;
    n = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(v[i*DW +: DW]);
      if (d > BASE - 1) d = BASE - 1;
      n = n + d * w;
      w = w * BASE;
    end
    return n;
  endfunction

  function automatic logic [DIGITS-1:0] modelDigTc(input int unsigned n, input logic upV);
    logic [DIGITS-1:0] t;
    int unsigned       v;
    int unsigned       d;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      d = v % BASE;
      t[i] = upV ? (d == BASE - 1) : (d == 0);
      v = v / BASE;
    end
    return t;
  endfunction

  function automatic logic modelTc(input int unsigned n, input logic upV);
    return upV ? (n == MODN - 1) : (n == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational flags before the
  // edge, then advance the model and check Q after the edge.
  task automatic applyStimulus(input logic clrV, input logic ldV, input logic ceV,
                               input logic upV, input logic satV, input logic [W-1:0] dinV);
    logic expTc;
    clr   = clrV;
    ld    = ldV;
    ce    = ceV;
    up    = upV;
    satIn = satV;
    din   = dinV;
    #1;
    expTc = modelTc(model, upV);
    checkOutput("dig_tc", 32'(digTc), 32'(modelDigTc(model, upV)));
    checkOutput("tc", 32'(tc), 32'(expTc));
    checkOutput("ceo", 32'(ceo), 32'(ceV & expTc & ~ldV & ~clrV));
    @(posedge clk);
    #1;
    if (clrV) begin
      model = 0;
    end else if (ldV) begin
      model = fromLoad(dinV);
    end else if (ceV) begin
      if (!(SAT_EN && satV && expTc)) begin
        model = upV ? (model + 1) % MODN : (model + MODN - 1) % MODN;
      end
    end
    checkOutput("q", 32'(q), 32'(toPacked(model)));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic upR;
    logic [W-1:0] dinR;

    r = 1'b1; clr = 1'b0; ld = 1'b0; ce = 1'b0; up = 1'b1; din = '0; satIn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_q", 32'(q), 32'h0);
    checkOutput("rst_tc_up", 32'(tc), 32'h0);
    up = 1'b0; ce = 1'b1;
    #1;
    checkOutput("rst_tc_dn", 32'(tc), 32'h1);
    checkOutput("rst_ceo_dn", 32'(ceo), 32'h1);
    r = 1'b0;
    model = 0;

    // Scenario 1: async reset mid-count, then count from zero.
    applyStimulus(0, 1, 0, 1, 0, 16'h1234);
    checkOutput("s1_load", 32'(q), 32'h1234);
    #2 r = 1'b1;
    #1 checkOutput("s1_async_q", 32'(q), 32'h0);
    model = 0;
    #1 r = 1'b0;
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    checkOutput("s1_first", 32'(q), 32'h0001);

    // Scenario 2: carry through lower digits.
    applyStimulus(0, 1, 1, 1, 0, 16'h0998);
    checkOutput("s2_load", 32'(q), 32'h0998);
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    checkOutput("s2_q1", 32'(q), 32'h0999);
    #1 checkOutput("s2_digtc", 32'(digTc), 32'h7);
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    checkOutput("s2_q2", 32'(q), 32'h1000);
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    checkOutput("s2_q3", 32'(q), 32'h1001);

    // Scenario 3: up wrap with one-cycle CEO.
    applyStimulus(0, 1, 0, 1, 0, 16'h9998);
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    #1 checkOutput("s3_ceo_hi", 32'(ceo), 32'h1);
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    checkOutput("s3_wrap", 32'(q), 32'h0000);
    #1 checkOutput("s3_ceo_lo", 32'(ceo), 32'h0);

    // Scenario 4: down wrap and direction change.
    applyStimulus(0, 1, 0, 0, 0, 16'h0001);
    applyStimulus(0, 0, 1, 0, 0, 16'h0);
    checkOutput("s4_zero", 32'(q), 32'h0000);
    applyStimulus(0, 0, 1, 0, 0, 16'h0);
    checkOutput("s4_wrap", 32'(q), 32'h9999);
    applyStimulus(0, 1, 0, 0, 0, 16'h0500);
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    checkOutput("s4_toggle", 32'(q), 32'h0501);

    // Scenario 5: priority and clamp.
    applyStimulus(0, 1, 0, 1, 0, 16'h4321);
    applyStimulus(1, 1, 1, 1, 0, 16'h5555);
    checkOutput("s5_clr", 32'(q), 32'h0000);
    applyStimulus(0, 1, 1, 1, 0, 16'h0F3C);
    checkOutput("s5_clamp", 32'(q), 32'h0939);

`ifdef BCD_CHAIN_SAT_EN
    // Scenario 6: saturation holds, then wraps once sat drops.
    applyStimulus(0, 1, 0, 1, 1, 16'h9999);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 1, 16'h0);
      checkOutput("s6_hold", 32'(q), 32'h9999);
      #1 checkOutput("s6_ceo", 32'(ceo), 32'h1);
    end
    applyStimulus(0, 0, 1, 1, 0, 16'h0);
    checkOutput("s6_wrap", 32'(q), 32'h0000);
`endif

    // Randomized phase, biased toward chain boundaries.
    upR = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) upR = ~upR;
      case ($urandom_range(0, 3))
        0:       dinR = W'($urandom);
        1:       dinR = 16'h9990 | W'($urandom_range(0, 9));
        2:       dinR = W'($urandom_range(0, 9));
        default: dinR = toPacked($urandom_range(0, MODN - 1));
      endcase
      if ($urandom_range(0, 59) == 0) begin
        #2 r = 1'b1;
        #1 checkOutput("rnd_async_q", 32'(q), 32'h0);
        model = 0;
        #1 r = 1'b0;
      end
      applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) != 0, upR, 1'($urandom_range(0, 1)), dinR);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
